// File: rtl/wb_arbiter_rr2.sv
// Two-master, one-slave Wishbone B3 round-robin arbiter; grant is held for the whole cyc.
// Optional bus watchdog enabled by defining WB_ARB_WATCHDOG_EN (limit set by TIMEOUT).
//
// state | meaning
// IDLE  | no master owns the slave; s_* driven to zero
// GNT0  | m0 owns the slave until m0_cyc_i drops
// GNT1  | m1 owns the slave until m1_cyc_i drops
module wb_arbiter_rr2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,

    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;

    logic       mux_stb;
    logic       term;
    logic       wdog_fire;

    // Round-robin: on simultaneous requests from IDLE the master that was not served last wins.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_d = GNT0;
                else if (m1_cyc_i)        state_d = GNT1;
            end
            GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
            GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
        if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
        gnt_d = {state_d == GNT1, state_d == GNT0};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o = gnt_q;
    assign term  = s_ack_i | s_err_i | s_rty_i;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        mux_stb = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        if (gnt_q[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            mux_stb = m0_stb_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (gnt_q[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            mux_stb = m1_stb_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] wdog_q, wdog_d;

    // The timeout err stands in for the slave's termination, so it never coincides with a real one.
    assign wdog_fire = s_cyc_o & mux_stb & ~term & (wdog_q == WDOG_LIMIT);

    always_comb begin
        wdog_d = wdog_q;
        if (gnt_d != gnt_q || term || wdog_fire) wdog_d = '0;
        else if (s_cyc_o && mux_stb)             wdog_d = wdog_q + 16'd1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) wdog_q <= '0;
        else             wdog_q <= wdog_d;
    end
`else
    assign wdog_fire = 1'b0;
`endif

    assign s_stb_o  = mux_stb & ~wdog_fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = gnt_q[0] & s_ack_i;
    assign m1_ack_o = gnt_q[1] & s_ack_i;
    assign m0_err_o = gnt_q[0] & (s_err_i | wdog_fire);
    assign m1_err_o = gnt_q[1] & (s_err_i | wdog_fire);
    assign m0_rty_o = gnt_q[0] & s_rty_i;
    assign m1_rty_o = gnt_q[1] & s_rty_i;

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Directed bench for wb_arbiter_rr2: reset, solo read, alternation, burst lock, abort, stall.
// Covers both builds; the stall step expects the watchdog err only with WB_ARB_WATCHDOG_EN.
module tb_wb_arbiter_rr2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]  m0_cti_i, m1_cti_i;
    logic [1:0]  m0_bte_i, m1_bte_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;

    int tests  = 0;
    int failed = 0;

    wb_arbiter_rr2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        m0_adr_i = 32'h0000_00A0; m0_dat_i = 32'h1111_0000; m0_sel_i = 4'hF; m0_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000; m0_bte_i = 2'b01;
        m1_adr_i = 32'h0000_0100; m1_dat_i = 32'h2222_0000; m1_sel_i = 4'h3; m1_we_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b000; m1_bte_i = 2'b10;
        s_dat_i = 32'h0; s_ack_i = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0;

        // Reset held with both masters requesting
        tick(); tick();
        chk("rst_gnt",     32'(gnt_o),    32'h0);
        chk("rst_s_cyc",   32'(s_cyc_o),  32'h0);
        chk("rst_s_stb",   32'(s_stb_o),  32'h0);
        chk("rst_s_adr",   s_adr_o,       32'h0);
        chk("rst_m0_ack",  32'(m0_ack_o), 32'h0);
        chk("rst_m1_ack",  32'(m1_ack_o), 32'h0);
        s_ack_i = 1'b0;
        wb_rst_n_i = 1'b1;
        #1 chk("rel_gnt_pre", 32'(gnt_o), 32'h0);
        tick();
        chk("rel_gnt",     32'(gnt_o),    32'h1);
        chk("rel_s_adr",   s_adr_o,       32'h0000_00A0);
        chk("rel_s_cyc",   32'(s_cyc_o),  32'h1);
        chk("rel_s_bte",   32'(s_bte_o),  32'h1);

        // m0 completes, m1 takes over with no idle cycle
        s_ack_i = 1'b1;
        #1 chk("m0_ack",   32'(m0_ack_o), 32'h1);
        chk("m1_ack_gated", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1 chk("drop_gnt", 32'(gnt_o),    32'h1);
        chk("drop_s_cyc",  32'(s_cyc_o),  32'h0);
        tick();
        chk("hand_gnt",    32'(gnt_o),    32'h2);
        chk("hand_s_adr",  s_adr_o,       32'h0000_0100);
        chk("hand_s_we",   32'(s_we_o),   32'h1);
        chk("hand_s_sel",  32'(s_sel_o),  32'h3);

        // Solo m1 read of 0xDEADBEEF
        s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1; m1_we_i = 1'b0;
        #1 chk("rd_m1_dat", m1_dat_o,     32'hDEAD_BEEF);
        chk("rd_m1_ack",   32'(m1_ack_o), 32'h1);
        chk("rd_m0_ack",   32'(m0_ack_o), 32'h0);
        chk("rd_gnt",      32'(gnt_o),    32'h2);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("idle_gnt",    32'(gnt_o),    32'h0);
        chk("idle_s_adr",  s_adr_o,       32'h0);
        chk("idle_s_cti",  32'(s_cti_o),  32'h0);

        // Alternation: m1 was last, so m0 wins, then m1 wins next contention
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        chk("alt1_gnt",    32'(gnt_o),    32'h1);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();
        chk("alt_idle",    32'(gnt_o),    32'h0);
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        chk("alt2_gnt",    32'(gnt_o),    32'h2);
        m1_cyc_i = 1'b0;
        tick();
        chk("alt3_gnt",    32'(gnt_o),    32'h1);
        m0_cyc_i = 1'b0;
        tick();
        chk("alt3_idle",   32'(gnt_o),    32'h0);

        // m0 4-beat burst while m1 waits (m0 was last, so m1 would win a fresh tie)
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("pre_burst_gnt", 32'(gnt_o),  32'h2);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010; m0_adr_i = 32'h0000_1000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("burst_gnt",   32'(gnt_o),    32'h1);
        for (int i = 0; i < 4; i++) begin
            m0_cti_i = (i == 3) ? 3'b111 : 3'b010;
            m0_adr_i = 32'h0000_1000 + 32'(4 * i);
            s_ack_i  = 1'b1;
            #1;
            chk("burst_m0_ack", 32'(m0_ack_o), 32'h1);
            chk("burst_m1_ack", 32'(m1_ack_o), 32'h0);
            chk("burst_s_cti",  32'(s_cti_o),  32'(m0_cti_i));
            chk("burst_s_adr",  s_adr_o,       32'h0000_1000 + 32'(4 * i));
            tick();
        end
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000;
        #1 chk("burst_end_gnt", 32'(gnt_o), 32'h1);
        tick();
        chk("burst_hand_gnt", 32'(gnt_o), 32'h2);

        // m1 aborts without termination: first to IDLE, then to GNT0
        tick();
        chk("wait_gnt",    32'(gnt_o),    32'h2);
        chk("wait_m1_ack", 32'(m1_ack_o), 32'h0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("abort_idle",  32'(gnt_o),    32'h0);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("abort2_gnt1", 32'(gnt_o),    32'h2);
        m0_cyc_i = 1'b1;
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("abort2_gnt0", 32'(gnt_o),    32'h1);

        // cyc high with stb low keeps the grant without a slave strobe
        chk("nostb_s_stb", 32'(s_stb_o),  32'h0);
        chk("nostb_s_cyc", 32'(s_cyc_o),  32'h1);
        tick();
        chk("nostb_gnt",   32'(gnt_o),    32'h1);

        // Stalled slave: with TIMEOUT=8 the watchdog fires in the 8th strobe cycle
        m0_stb_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
`ifdef WB_ARB_WATCHDOG_EN
            chk("stall_m0_err", 32'(m0_err_o), (i == 8) ? 32'h1 : 32'h0);
            chk("stall_s_stb",  32'(s_stb_o),  (i == 8) ? 32'h0 : 32'h1);
`else
            chk("stall_m0_err", 32'(m0_err_o), 32'h0);
            chk("stall_s_stb",  32'(s_stb_o),  32'h1);
`endif
            chk("stall_m1_err", 32'(m1_err_o), 32'h0);
            chk("stall_gnt",    32'(gnt_o),    32'h1);
            tick();
        end

        // err/rty pass through to the granted master only
        s_err_i = 1'b1;
        #1 chk("err_m0",   32'(m0_err_o), 32'h1);
        chk("err_m1",      32'(m1_err_o), 32'h0);
        s_err_i = 1'b0; s_rty_i = 1'b1;
        #1 chk("rty_m0",   32'(m0_rty_o), 32'h1);
        chk("rty_m1",      32'(m1_rty_o), 32'h0);
        s_rty_i = 1'b0;
        tick();

        // Reset mid-cycle drops the grant immediately
        #1 wb_rst_n_i = 1'b0;
        #1 chk("midrst_gnt", 32'(gnt_o),  32'h0);
        chk("midrst_s_cyc", 32'(s_cyc_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
